// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed RED/IR FIR engine.
// Holds the default widths, the symmetric coefficient half-set, the FSM
// state enum and the channel-select enum used by fir_mac_scheduler and
// fir_hist_buf.
package fir_pkg;

  localparam int unsigned TAPS  = 21;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 8;
  localparam int unsigned OW    = 20;
  localparam int unsigned NPAIR = TAPS / 2 + 1;
  localparam int unsigned KW    = 4;

  // c[0..10]; c[10] is the centre tap, applied to 2*h[10] to keep existing gain.
  localparam logic [CW-1:0] COEF [NPAIR] = '{
    8'd2, 8'd10, 8'd16, 8'd28, 8'd43, 8'd60,
    8'd78, 8'd95, 8'd111, 8'd122, 8'd128
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } fir_state_t;

  typedef enum logic {
    CH_RED,
    CH_IR
  } fir_ch_t;

  // Coefficient lookup; indices past the last pair return zero.
  function automatic logic [CW-1:0] coef_at(input logic [KW-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NPAIR; i++) begin
      if (32'(k) == i) c = COEF[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/fir_hist_buf.sv
// Per-channel sample store for the FIR engine.
// Latches incoming samples into a pending register (with pend flag and
// sticky overrun flag) and shifts the granted sample into a TAPS-deep
// history. Presents the symmetric pre-add h[k] + h[TAPS-1-k] for index k.
//   CLK_Filter  : clock, rising edge
//   rst         : synchronous active-high reset
//   sample_vld  : one-cycle strobe qualifying sample
//   sample      : ADC value
//   grant       : shift pending value into history and clear pend
//   k           : pre-add pair index (0..TAPS/2)
//   pend        : a sample is waiting for a grant
//   overrun     : sticky, a pending sample was overwritten before grant
//   preadd      : DW+1 bit unsigned pre-add for pair k
module fir_hist_buf
  import fir_pkg::*;
#(
  parameter int unsigned TAPS = fir_pkg::TAPS,
  parameter int unsigned DW   = fir_pkg::DW
) (
  input  logic          CLK_Filter,
  input  logic          rst,
  input  logic          sample_vld,
  input  logic [DW-1:0] sample,
  input  logic          grant,
  input  logic [KW-1:0] k,
  output logic          pend,
  output logic          overrun,
  output logic [DW:0]   preadd
);

  logic [DW-1:0] pend_sample;
  logic [DW-1:0] hist [TAPS];
  logic [DW-1:0] lo;
  logic [DW-1:0] hi;

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      pend_sample <= '0;
      pend        <= 1'b0;
      overrun     <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) hist[i] <= '0;
    end else begin
      // The grant consumes the value latched before this edge, so a
      // coincident strobe refills pend without counting as an overrun.
      if (grant) begin
        hist[0] <= pend_sample;
        for (int unsigned i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
      end
      if (sample_vld) begin
        pend_sample <= sample;
        pend        <= 1'b1;
        if (pend && !grant) overrun <= 1'b1;
      end else if (grant) begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    lo = '0;
    hi = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (i == 32'(k))            lo = hist[i];
      if (TAPS - 1 - i == 32'(k)) hi = hist[i];
    end
    preadd = {1'b0, lo} + {1'b0, hi};
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR engine controller for the RED and IR channels.
// Two history buffers share one multiplier/accumulator, sequenced over the
// symmetric coefficient pairs; each accepted sample yields one filtered
// result with a one-cycle valid pulse.
//   CLK_Filter                : clock, rising edge
//   rst                       : synchronous active-high reset
//   red_sample_vld/red_sample : RED sample strobe and value
//   ir_sample_vld/ir_sample   : IR sample strobe and value
//   out_red/out_red_vld       : last RED result (held) and update pulse
//   out_ir/out_ir_vld         : last IR result (held) and update pulse
//   busy                      : high while in MAC or OUT
//   overrun_red/overrun_ir    : sticky pending-overwrite flags
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int unsigned TAPS = fir_pkg::TAPS,
  parameter int unsigned DW   = fir_pkg::DW,
  parameter int unsigned CW   = fir_pkg::CW,
  parameter int unsigned OW   = fir_pkg::OW
) (
  input  logic          CLK_Filter,
  input  logic          rst,
  input  logic          red_sample_vld,
  input  logic [DW-1:0] red_sample,
  input  logic          ir_sample_vld,
  input  logic [DW-1:0] ir_sample,
  output logic [OW-1:0] out_red,
  output logic          out_red_vld,
  output logic [OW-1:0] out_ir,
  output logic          out_ir_vld,
  output logic          busy,
  output logic          overrun_red,
  output logic          overrun_ir
);

  localparam int unsigned PW = CW + DW + 1;

  fir_state_t     st;
  fir_ch_t        gch;
  fir_ch_t        last_grant;
  logic [OW-1:0]  acc;
  logic [KW-1:0]  k;

  logic           pend_red;
  logic           pend_ir;
  logic [DW:0]    preadd_red;
  logic [DW:0]    preadd_ir;
  logic [DW:0]    preadd_sel;
  logic [PW-1:0]  prod;
  logic           grant_any;
  logic           pick_red;
  logic           grant_red;
  logic           grant_ir;

  fir_hist_buf #(
    .TAPS (TAPS),
    .DW   (DW)
  ) u_hist_red (
    .CLK_Filter (CLK_Filter),
    .rst        (rst),
    .sample_vld (red_sample_vld),
    .sample     (red_sample),
    .grant      (grant_red),
    .k          (k),
    .pend       (pend_red),
    .overrun    (overrun_red),
    .preadd     (preadd_red)
  );

  fir_hist_buf #(
    .TAPS (TAPS),
    .DW   (DW)
  ) u_hist_ir (
    .CLK_Filter (CLK_Filter),
    .rst        (rst),
    .sample_vld (ir_sample_vld),
    .sample     (ir_sample),
    .grant      (grant_ir),
    .k          (k),
    .pend       (pend_ir),
    .overrun    (overrun_ir),
    .preadd     (preadd_ir)
  );

  // Grants are issued from IDLE and from OUT, so back-to-back results
  // need no extra idle cycle. Ties go to the channel not served last.
  always_comb begin
    pick_red   = pend_red && (!pend_ir || (last_grant == CH_IR));
    grant_any  = ((st == ST_IDLE) || (st == ST_OUT)) && (pend_red || pend_ir);
    grant_red  = grant_any && pick_red;
    grant_ir   = grant_any && !pick_red;
    preadd_sel = (gch == CH_RED) ? preadd_red : preadd_ir;
    prod       = PW'(coef_at(k)) * PW'(preadd_sel);
  end

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      st          <= ST_IDLE;
      gch         <= CH_RED;
      last_grant  <= CH_IR;
      acc         <= '0;
      k           <= '0;
      out_red     <= '0;
      out_ir      <= '0;
      out_red_vld <= 1'b0;
      out_ir_vld  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      out_red_vld <= 1'b0;
      out_ir_vld  <= 1'b0;

      case (st)
        ST_IDLE: begin
          busy <= 1'b0;
        end
        ST_MAC: begin
          acc <= acc + OW'(prod);
          k   <= k + 1'b1;
          if (k == KW'(NPAIR - 1)) st <= ST_OUT;
        end
        ST_OUT: begin
          if (gch == CH_RED) begin
            out_red     <= acc;
            out_red_vld <= 1'b1;
          end else begin
            out_ir      <= acc;
            out_ir_vld  <= 1'b1;
          end
          st   <= ST_IDLE;
          busy <= 1'b0;
        end
        default: begin
          st   <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase

      // Shared grant path for IDLE and OUT; overrides the OUT->IDLE move.
      if (grant_any) begin
        gch        <= grant_red ? CH_RED : CH_IR;
        last_grant <= grant_red ? CH_RED : CH_IR;
        acc        <= '0;
        k          <= '0;
        st         <= ST_MAC;
        busy       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: directed scenarios plus a
// randomized dual-channel run compared against a plain-arithmetic FIR model.
module tb_fir_mac_scheduler;

  logic        CLK_Filter = 1'b0;
  logic        rst = 1'b1;
  logic        red_sample_vld = 1'b0;
  logic [7:0]  red_sample = '0;
  logic        ir_sample_vld = 1'b0;
  logic [7:0]  ir_sample = '0;
  logic [19:0] out_red;
  logic        out_red_vld;
  logic [19:0] out_ir;
  logic        out_ir_vld;
  logic        busy;
  logic        overrun_red;
  logic        overrun_ir;

  fir_mac_scheduler #(
    .TAPS (21),
    .DW   (8),
    .CW   (8),
    .OW   (20)
  ) dut (
    .CLK_Filter     (CLK_Filter),
    .rst            (rst),
    .red_sample_vld (red_sample_vld),
    .red_sample     (red_sample),
    .ir_sample_vld  (ir_sample_vld),
    .ir_sample      (ir_sample),
    .out_red        (out_red),
    .out_red_vld    (out_red_vld),
    .out_ir         (out_ir),
    .out_ir_vld     (out_ir_vld),
    .busy           (busy),
    .overrun_red    (overrun_red),
    .overrun_ir     (overrun_ir)
  );

  always #5 CLK_Filter = ~CLK_Filter;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_red_cyc = 0;
  int last_ir_cyc = 0;
  int red_pulses = 0;
  int ir_pulses = 0;
  int got_red[$];
  int got_ir[$];
  int exp_red[$];
  int exp_ir[$];
  int mh_red[21];
  int mh_ir[21];
  int coef[11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // y = sum c[k]*(h[k]+h[20-k]), h[0] newest
  function automatic int fir_ref(input int h[21]);
    int s;
    s = 0;
    for (int kk = 0; kk < 11; kk++) s += coef[kk] * (h[kk] + h[20-kk]);
    return s;
  endfunction

  task automatic push_red(input int v);
    for (int i = 20; i > 0; i--) mh_red[i] = mh_red[i-1];
    mh_red[0] = v;
    exp_red.push_back(fir_ref(mh_red));
  endtask

  task automatic push_ir(input int v);
    for (int i = 20; i > 0; i--) mh_ir[i] = mh_ir[i-1];
    mh_ir[0] = v;
    exp_ir.push_back(fir_ref(mh_ir));
  endtask

  task automatic tick();
    @(posedge CLK_Filter);
    #1;
    cyc++;
    if (out_red_vld) begin
      got_red.push_back(int'(out_red));
      last_red_cyc = cyc;
      red_pulses++;
    end
    if (out_ir_vld) begin
      got_ir.push_back(int'(out_ir));
      last_ir_cyc = cyc;
      ir_pulses++;
    end
  endtask

  task automatic strobe(input bit r, input int rv, input bit i, input int iv);
    red_sample_vld = r;
    red_sample     = 8'(rv);
    ir_sample_vld  = i;
    ir_sample      = 8'(iv);
    if (r) push_red(rv);
    if (i) push_ir(iv);
    tick();
    red_sample_vld = 1'b0;
    ir_sample_vld  = 1'b0;
  endtask

  task automatic clear_model();
    got_red.delete(); got_ir.delete(); exp_red.delete(); exp_ir.delete();
    for (int i = 0; i < 21; i++) begin
      mh_red[i] = 0;
      mh_ir[i]  = 0;
    end
    red_pulses = 0;
    ir_pulses  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic check_red(input string tag);
    chk({tag, "_red_count"}, got_red.size(), exp_red.size());
    for (int i = 0; i < got_red.size() && i < exp_red.size(); i++)
      chk($sformatf("%s_red_val%0d", tag, i), got_red[i], exp_red[i]);
    got_red.delete();
    exp_red.delete();
  endtask

  task automatic check_ir(input string tag);
    chk({tag, "_ir_count"}, got_ir.size(), exp_ir.size());
    for (int i = 0; i < got_ir.size() && i < exp_ir.size(); i++)
      chk($sformatf("%s_ir_val%0d", tag, i), got_ir[i], exp_ir[i]);
    got_ir.delete();
    exp_ir.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int rv;
    int rb;
    int next_r;
    int next_i;
    bit r;
    bit i;

    // Reset state
    do_reset();
    chk("rst_out_red", out_red, 0);
    chk("rst_out_ir", out_ir, 0);
    chk("rst_red_vld", out_red_vld, 0);
    chk("rst_ir_vld", out_ir_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr_red", overrun_red, 0);
    chk("rst_ovr_ir", overrun_ir, 0);

    // RED impulse followed by zeros, 30-cycle spacing
    for (int s = 0; s < 13; s++) begin
      strobe(1'b1, (s == 0) ? 255 : 0, 1'b0, 0);
      e0 = cyc;
      repeat (29) tick();
      chk($sformatf("imp_lat%0d", s), last_red_cyc - e0, 13);
      if (s == 0)  chk("imp_first", out_red, 510);
      if (s == 1)  chk("imp_second", out_red, 2550);
      if (s == 2)  chk("imp_third", out_red, 4080);
      if (s == 10) chk("imp_11th", out_red, 65280);
    end
    check_red("imp");
    chk("imp_no_ir_vld", ir_pulses, 0);

    // RED held at 255 for 21 samples, IR fed 0
    do_reset();
    for (int s = 0; s < 21; s++) begin
      strobe(1'b1, 255, 1'b1, 0);
      repeat (29) tick();
    end
    chk("dc_red_full", out_red, 353430);
    chk("dc_ir_zero", out_ir, 0);
    check_red("dc");
    check_ir("dc");

    // Simultaneous strobe: RED wins first tie, IR follows one service later
    do_reset();
    strobe(1'b1, 0, 1'b1, 100);
    e0 = cyc;
    tick();
    chk("tie_busy", busy, 1);
    repeat (28) tick();
    chk("tie_red_lat", last_red_cyc - e0, 13);
    chk("tie_ir_lat", last_ir_cyc - e0, 25);
    chk("tie_out_ir", out_ir, 200);
    chk("tie_out_red", out_red, 0);
    chk("tie_idle_busy", busy, 0);
    check_red("tie");
    check_ir("tie");

    // IR overwritten while RED is being served
    do_reset();
    rv = int'($urandom_range(0, 255));
    strobe(1'b1, rv, 1'b1, 50);
    tick();
    tick();
    strobe(1'b0, 0, 1'b1, 80);
    repeat (30) tick();
    chk("ovr_ir_set", overrun_ir, 1);
    chk("ovr_red_clear", overrun_red, 0);
    chk("ovr_out_ir", out_ir, 160);
    chk("ovr_out_red", out_red, 2 * rv);
    repeat (10) tick();
    chk("ovr_ir_sticky", overrun_ir, 1);
    chk("ovr_ir_pulses", ir_pulses, 1);
    clear_model();

    // Reset during RED MAC abandons the result and clears history
    do_reset();
    strobe(1'b1, 255, 1'b0, 0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    repeat (20) tick();
    chk("mid_rst_no_vld", red_pulses, 0);
    chk("mid_rst_out_red", out_red, 0);
    chk("mid_rst_busy", busy, 0);
    strobe(1'b1, 255, 1'b0, 0);
    repeat (29) tick();
    chk("mid_rst_impulse", out_red, 510);
    check_red("mid_rst");

    // RED strobe coincident with its own grant cycle
    do_reset();
    rv = int'($urandom_range(0, 255));
    rb = int'($urandom_range(0, 255));
    strobe(1'b1, rv, 1'b0, 0);
    e0 = cyc;
    strobe(1'b1, rb, 1'b0, 0);
    repeat (30) tick();
    chk("regrant_pulses", red_pulses, 2);
    chk("regrant_lat2", last_red_cyc - e0, 25);
    chk("regrant_ovr", overrun_red, 0);
    check_red("regrant");

    // Randomized dual-channel traffic with safe per-channel spacing
    do_reset();
    next_r = cyc + int'($urandom_range(0, 10));
    next_i = cyc + int'($urandom_range(0, 10));
    for (int n = 0; n < 800; n++) begin
      r = (cyc >= next_r);
      i = (cyc >= next_i);
      if (r) next_r = cyc + 30 + int'($urandom_range(0, 15));
      if (i) next_i = cyc + 30 + int'($urandom_range(0, 15));
      if (r || i)
        strobe(r, int'($urandom_range(0, 255)), i, int'($urandom_range(0, 255)));
      else
        tick();
    end
    repeat (40) tick();
    check_red("rnd");
    check_ir("rnd");
    chk("rnd_ovr_red", overrun_red, 0);
    chk("rnd_ovr_ir", overrun_ir, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
